// File: rtl/axa_add_requester_pkg.sv
// Shared definitions for the 2x2 matrix-add requester.
// Contents: default element width and watchdog limit, element slot indices
// inside a packed {X11,X12,X21,X22} vector (X11 in the MSBs), the FSM state
// encoding, and a helper that turns a slot index into a bit offset.
package axa_add_requester_pkg;

  localparam int unsigned AXA_DEFAULT_WIDTH   = 32;
  localparam int unsigned AXA_DEFAULT_TIMEOUT = 1023;

  // Slot index of each element in a packed 4-element word; slot 0 is the LSBs.
  localparam int unsigned AXA_IDX_11 = 3;
  localparam int unsigned AXA_IDX_12 = 2;
  localparam int unsigned AXA_IDX_21 = 1;
  localparam int unsigned AXA_IDX_22 = 0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_WAIT_RES = 3'd2,
    ST_ACK      = 3'd3,
    ST_OUT      = 3'd4
  } axa_state_e;

  // Bit offset of element slot idx, for use as vec[axa_lsb(idx, w) +: w].
  function automatic int unsigned axa_lsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/axa_req_watchdog.sv
// Handshake watchdog for axa_add_requester.
// Ports:
//   clk_i     - clock, rising edge
//   rst_i     - synchronous active-high reset
//   clear_i   - restart the count (job accepted, REQ is next)
//   run_i     - count this cycle (requester is waiting on the adder)
//   expire_o  - this is the last permitted waiting cycle; abort at the next edge
module axa_req_watchdog #(
  parameter int unsigned LIMIT = 1023
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic run_i,
  output logic expire_o
);

  localparam int unsigned CW = ($clog2(LIMIT + 1) > 10) ? $clog2(LIMIT + 1) : 10;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear on job acceptance, advance while waiting, else hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The count was cleared on REQ entry, so the LIMIT-th waiting cycle sees LIMIT-1.
  assign expire_o = run_i && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/axa_add_requester.sv
// Initiator side of the 2x2 matrix-add handshake (Start / AB_Ack / Stable / C_Ack).
// Takes a job {A,B} on a valid/ready port, runs one four-phase exchange with the
// adder, captures C and offers it downstream on a valid/ready port. Element data
// is opaque. All outputs come straight from registers.
// Ports:
//   input_Clk, input_Reset (sync, active high)
//   input_Job_Valid / output_Job_Ready, input_Job_A, input_Job_B : job in
//   output_A, output_B, output_Start, input_AB_Ack               : operands out
//   input_Stable, input_C, output_C_Ack                          : result in
//   output_Res_Valid / input_Res_Ready, output_Res_C             : result out
//   output_Error (watchdog abort), output_Jobs_Done (mod 2^16 delivery count)
// Optional build macro: AXA_REQ_TIMEOUT_EN enables the TIMEOUT_CYCLES watchdog;
// without it the block waits on the adder indefinitely and output_Error stays 0.
module axa_add_requester
  import axa_add_requester_pkg::*;
#(
  parameter int unsigned WIDTH          = AXA_DEFAULT_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = AXA_DEFAULT_TIMEOUT
) (
  input  logic               input_Clk,
  input  logic               input_Reset,
  input  logic               input_Job_Valid,
  output logic               output_Job_Ready,
  input  logic [4*WIDTH-1:0] input_Job_A,
  input  logic [4*WIDTH-1:0] input_Job_B,
  output logic [4*WIDTH-1:0] output_A,
  output logic [4*WIDTH-1:0] output_B,
  output logic               output_Start,
  input  logic               input_AB_Ack,
  input  logic               input_Stable,
  input  logic [4*WIDTH-1:0] input_C,
  output logic               output_C_Ack,
  output logic               output_Res_Valid,
  input  logic               input_Res_Ready,
  output logic [4*WIDTH-1:0] output_Res_C,
  output logic               output_Error,
  output logic [15:0]        output_Jobs_Done
);

  axa_state_e         state_q, state_d;
  logic               job_ready_q, job_ready_d;
  logic [4*WIDTH-1:0] a_q, a_d;
  logic [4*WIDTH-1:0] b_q, b_d;
  logic [4*WIDTH-1:0] res_c_q, res_c_d;
  logic               start_q, start_d;
  logic               c_ack_q, c_ack_d;
  logic               res_valid_q, res_valid_d;
  logic               error_q, error_d;
  logic [15:0]        jobs_done_q, jobs_done_d;
  logic               accept_s;
  logic               expire_s;

  assign accept_s = (state_q == ST_IDLE) && input_Job_Valid && job_ready_q;

`ifdef AXA_REQ_TIMEOUT_EN
  logic run_s;
  assign run_s = (state_q == ST_REQ) || (state_q == ST_WAIT_RES) || (state_q == ST_ACK);

  axa_req_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i    (input_Clk),
    .rst_i    (input_Reset),
    .clear_i  (accept_s),
    .run_i    (run_s),
    .expire_o (expire_s)
  );
`else
  logic [31:0] timeout_unused_s;
  assign timeout_unused_s = 32'(TIMEOUT_CYCLES);
  assign expire_s         = 1'b0;
`endif

  // Next-state and next-output logic of the handshake FSM.
  always_comb begin
    state_d     = state_q;
    job_ready_d = job_ready_q;
    a_d         = a_q;
    b_d         = b_q;
    res_c_d     = res_c_q;
    start_d     = start_q;
    c_ack_d     = c_ack_q;
    res_valid_d = res_valid_q;
    error_d     = error_q;
    jobs_done_d = jobs_done_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          a_d         = input_Job_A;
          b_d         = input_Job_B;
          job_ready_d = 1'b0;
          start_d     = 1'b1;
          state_d     = ST_REQ;
        end else begin
          job_ready_d = 1'b1;
        end
      end
      ST_REQ: begin
        if (expire_s) begin
          start_d     = 1'b0;
          c_ack_d     = 1'b0;
          res_c_d     = '0;
          error_d     = 1'b1;
          res_valid_d = 1'b1;
          state_d     = ST_OUT;
        end else if (input_AB_Ack && input_Stable) begin
          // Adder answered in the same cycle it took the operands.
          start_d = 1'b0;
          res_c_d = input_C;
          c_ack_d = 1'b1;
          state_d = ST_ACK;
        end else if (input_AB_Ack) begin
          start_d = 1'b0;
          state_d = ST_WAIT_RES;
        end else begin
          start_d = 1'b1;
        end
      end
      ST_WAIT_RES: begin
        if (expire_s) begin
          c_ack_d     = 1'b0;
          res_c_d     = '0;
          error_d     = 1'b1;
          res_valid_d = 1'b1;
          state_d     = ST_OUT;
        end else if (input_Stable) begin
          res_c_d = input_C;
          c_ack_d = 1'b1;
          state_d = ST_ACK;
        end else begin
          c_ack_d = 1'b0;
        end
      end
      ST_ACK: begin
        if (expire_s) begin
          c_ack_d     = 1'b0;
          res_c_d     = '0;
          error_d     = 1'b1;
          res_valid_d = 1'b1;
          state_d     = ST_OUT;
        end else if (!input_Stable) begin
          c_ack_d     = 1'b0;
          res_valid_d = 1'b1;
          state_d     = ST_OUT;
        end else begin
          c_ack_d = 1'b1;
        end
      end
      ST_OUT: begin
        if (input_Res_Ready) begin
          res_valid_d = 1'b0;
          error_d     = 1'b0;
          jobs_done_d = jobs_done_q + 16'd1;
          // Ready is raised by IDLE one cycle later, never alongside Res_Valid.
          job_ready_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          res_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        job_ready_d = 1'b1;
        start_d     = 1'b0;
        c_ack_d     = 1'b0;
        res_valid_d = 1'b0;
        error_d     = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge input_Clk) begin
    if (input_Reset) begin
      state_q     <= ST_IDLE;
      job_ready_q <= 1'b1;
      a_q         <= '0;
      b_q         <= '0;
      res_c_q     <= '0;
      start_q     <= 1'b0;
      c_ack_q     <= 1'b0;
      res_valid_q <= 1'b0;
      error_q     <= 1'b0;
      jobs_done_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      job_ready_q <= job_ready_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_c_q     <= res_c_d;
      start_q     <= start_d;
      c_ack_q     <= c_ack_d;
      res_valid_q <= res_valid_d;
      error_q     <= error_d;
      jobs_done_q <= jobs_done_d;
    end
  end

  assign output_Job_Ready = job_ready_q;
  assign output_A         = a_q;
  assign output_B         = b_q;
  assign output_Res_C     = res_c_q;
  assign output_Start     = start_q;
  assign output_C_Ack     = c_ack_q;
  assign output_Res_Valid = res_valid_q;
  assign output_Error     = error_q;
  assign output_Jobs_Done = jobs_done_q;

endmodule
